mem_arbiter: RTL and testbench

- Arbitrates the single-port, 16-bit, byte-addressed unified memory between the instruction-fetch requester (I, read-only) and the data requester (D, read/write).
- Models a fixed multi-cycle memory access latency around the zero-delay memory array.
- Sits between the fetch/cache-fill logic and the memory instance; owns all memory enable, write, address and data signals.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D arbiter for a single-port memory with fixed access latency
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [15:0]           i_rdata,
    output logic                  i_valid,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_valid,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic       OWN_I      = 1'b0;
    localparam logic       OWN_D      = 1'b1;
    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [3:0]            count_q, count_d;
    logic [15:0]           i_rdata_q, i_rdata_d;
    logic [15:0]           d_rdata_q, d_rdata_d;
    logic                  grant_d;
    logic                  access;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_I;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            count_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req) state_d = BUSY;
            BUSY:    if (count_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // D wins a tie unless it was the last one served.
    assign grant_d = d_req && (!i_req || (last_q == OWN_I));

    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (state_q == IDLE && (i_req || d_req)) begin
            owner_d = grant_d;
            last_d  = grant_d;
            wr_d    = grant_d & d_wr;
            addr_d  = grant_d ? {d_addr[ADDR_WIDTH-1:1], 1'b0} : {i_addr[ADDR_WIDTH-1:1], 1'b0};
            wdata_d = grant_d ? d_wdata : 16'h0000;
            count_d = COUNT_INIT;
        end else if (state_q == BUSY) begin
            if (count_q != 4'd0) begin
                count_d = count_q - 4'd1;
            end else if (!wr_q) begin
                if (owner_q == OWN_D) d_rdata_d = mem_data_out;
                else                  i_rdata_d = mem_data_out;
            end
        end
    end

    always_comb begin
        access      = (state_q == BUSY) && (count_q == 4'd0);
        mem_enable  = access;
        mem_wr      = access && wr_q;
        mem_addr    = addr_q;
        mem_data_in = wdata_q;
        busy        = (state_q != IDLE);
        i_valid     = (state_q == DONE) && (owner_q == OWN_I);
        d_valid     = (state_q == DONE) && (owner_q == OWN_D);
        i_rdata     = i_rdata_q;
        d_rdata     = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized transaction-level check of mem_arbiter (LATENCY 4) plus a LATENCY 1 build
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_init = 1'b1;

    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;
    logic        i_valid, d_valid, busy, mem_enable, mem_wr;

    logic        i1_req = 1'b0, d1_req = 1'b0, d1_wr = 1'b0;
    logic [15:0] i1_addr = '0, d1_addr = '0, d1_wdata = '0;
    logic [15:0] i1_rdata, d1_rdata, m1_addr, m1_din, m1_dout;
    logic        i1_valid, d1_valid, busy1, m1_en, m1_wr;

    logic [15:0] tb_mem [0:255];
    logic [15:0] mem1 [0:255];
    logic [15:0] ref_mem [0:31];

    int checks = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .busy(busy),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i1_req), .i_addr(i1_addr), .i_rdata(i1_rdata), .i_valid(i1_valid),
        .d_req(d1_req), .d_wr(d1_wr), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_rdata(d1_rdata), .d_valid(d1_valid), .busy(busy1),
        .mem_enable(m1_en), .mem_wr(m1_wr), .mem_addr(m1_addr),
        .mem_data_in(m1_din), .mem_data_out(m1_dout)
    );

    function automatic logic [15:0] init_val(input int k);
        if (k == 8)  return 16'hABCD;
        if (k >= 32) return 16'h0000;
        return 16'(k * 257) ^ 16'hA5C3;
    endfunction

    assign mem_data_out = tb_mem[mem_addr[8:1]];
    assign m1_dout      = mem1[m1_addr[8:1]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 256; k++) begin
                tb_mem[k] <= init_val(k);
                mem1[k]   <= init_val(k);
            end
        end else begin
            if (mem_enable && mem_wr) tb_mem[mem_addr[8:1]] <= mem_data_in;
            if (m1_en && m1_wr)       mem1[m1_addr[8:1]]    <= m1_din;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: one grant at a time, each occupying LAT+2 cycles.
    int          cyc = 0;
    int          g_e = 0;
    int          free_e = 0;
    bit          inflight = 0;
    bit          own_d = 0;
    bit          last_d = 0;
    bit          t_wr = 0;
    logic [15:0] t_addr = '0, t_wdata = '0;
    logic [15:0] exp_irdata = '0, exp_drdata = '0;
    bit          i_pend = 0, d_pend = 0;

    task automatic step(input bit allow_new);
        bit exp_en, exp_iv, exp_dv, exp_busy;
        exp_en   = inflight && (cyc == g_e + LAT);
        exp_iv   = inflight && !own_d && (cyc == g_e + LAT + 1);
        exp_dv   = inflight &&  own_d && (cyc == g_e + LAT + 1);
        exp_busy = inflight && (cyc > g_e) && (cyc <= g_e + LAT + 1);
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("i_valid", 32'(i_valid), 32'(exp_iv));
        check_eq("d_valid", 32'(d_valid), 32'(exp_dv));
        check_eq("mem_enable", 32'(mem_enable), 32'(exp_en));
        check_eq("mem_wr", 32'(mem_wr), 32'(exp_en && t_wr));
        check_eq("i_rdata", 32'(i_rdata), 32'(exp_irdata));
        check_eq("d_rdata", 32'(d_rdata), 32'(exp_drdata));
        if (exp_en) begin
            check_eq("mem_addr", 32'(mem_addr), 32'(t_addr));
            if (t_wr) begin
                check_eq("mem_data_in", 32'(mem_data_in), 32'(t_wdata));
                ref_mem[t_addr[5:1]] = t_wdata;
            end else if (own_d) begin
                exp_drdata = ref_mem[t_addr[5:1]];
            end else begin
                exp_irdata = ref_mem[t_addr[5:1]];
            end
        end
        if (exp_iv || exp_dv) inflight = 0;

        if (exp_iv) begin
            i_req = 1'b0; i_pend = 0;
        end else if (allow_new && !i_pend && $urandom_range(2) == 0) begin
            i_pend = 1; i_req = 1'b1; i_addr = 16'($urandom_range(63));
        end
        if (exp_dv) begin
            d_req = 1'b0; d_pend = 0;
        end else if (allow_new && !d_pend && $urandom_range(2) == 0) begin
            d_pend = 1; d_req = 1'b1; d_wr = 1'($urandom_range(1));
            d_addr = 16'($urandom_range(63)); d_wdata = 16'($urandom);
        end

        if (!inflight && cyc >= free_e && (i_req || d_req)) begin
            own_d    = d_req && (!i_req || !last_d);
            last_d   = own_d;
            inflight = 1;
            g_e      = cyc;
            free_e   = cyc + LAT + 2;
            t_addr   = (own_d ? d_addr : i_addr) & 16'hFFFE;
            t_wr     = own_d && d_wr;
            t_wdata  = d_wdata;
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) ref_mem[k] = init_val(k);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst valids", {30'd0, i_valid, d_valid}, 32'd0);
        check_eq("rst mem_enable", 32'(mem_enable), 32'd0);
        check_eq("rst rdata", {i_rdata, d_rdata}, 32'd0);
        mem_init = 1'b0;
        rst_n    = 1'b1;

        // LATENCY=1 build: I read of an odd address, then a quiet stretch.
        i1_req = 1'b1; i1_addr = 16'h0011;
        check_eq("l1 en idle", 32'(m1_en), 32'd0);
        @(negedge clk);
        check_eq("l1 en c1", 32'(m1_en), 32'd1);
        check_eq("l1 addr", 32'(m1_addr), 32'h0010);
        check_eq("l1 iv c1", 32'(i1_valid), 32'd0);
        @(negedge clk);
        i1_req = 1'b0;
        check_eq("l1 iv c2", 32'(i1_valid), 32'd1);
        check_eq("l1 rdata", 32'(i1_rdata), 32'hABCD);
        check_eq("l1 dv", 32'(d1_valid), 32'd0);
        check_eq("l1 en c2", 32'(m1_en), 32'd0);
        repeat (15) begin
            @(negedge clk);
            check_eq("l1 en quiet", 32'(m1_en), 32'd0);
        end

        cyc = 0; free_e = 0;
        repeat (1500) step(1'b1);
        repeat (20) step(1'b0);

        // Reset in the middle of a D write: nothing must reach memory.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0080; d_wdata = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre-rst busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort valids", {30'd0, i_valid, d_valid}, 32'd0);
        check_eq("abort mem_enable", {31'd0, mem_enable | mem_wr}, 32'd0);
        check_eq("abort rdata", {i_rdata, d_rdata}, 32'd0);
        d_req = 1'b0; d_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("abort mem", 32'(tb_mem[64]), 32'h0000);
        check_eq("abort idle", 32'(busy), 32'd0);

        exp_irdata = '0; exp_drdata = '0;
        inflight = 0; last_d = 0; i_pend = 0; d_pend = 0;
        free_e = cyc;
        repeat (800) step(1'b1);
        repeat (20) step(1'b0);

        for (int k = 0; k < 32; k++) check_eq("final mem", 32'(tb_mem[k]), 32'(ref_mem[k]));

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
